// File: rtl/medidor_linea_pkg.sv
// rtl/medidor_linea_pkg.sv - shared types and constants for the line-mark period meter
package medidor_linea_pkg;

  typedef enum logic [1:0] {
    INACTIVO = 2'd0,
    MIDIENDO = 2'd1,
    DETENIDO = 2'd2
  } estado_t;

  localparam int PROM_N    = 4;
  localparam int PROM_LOG2 = 2;

  localparam logic [15:0] MARCAS_MAX = 16'hFFFF;

  // Adds an 8-bit mark delta to the running total, clamping at all-ones.
  function automatic logic [15:0] suma_sat(input logic [15:0] total, input logic [7:0] delta);
    logic [16:0] s;
    s = {1'b0, total} + {9'd0, delta};
    return s[16] ? MARCAS_MAX : s[15:0];
  endfunction

endpackage

// File: rtl/promedio_periodo.sv
// rtl/promedio_periodo.sv - 4-deep shift register with running sum and registered mean
module promedio_periodo
  import medidor_linea_pkg::*;
#(
  parameter int PERIOD_W = 24
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push,
  input  logic                clear,
  input  logic                rearm,
  input  logic [PERIOD_W-1:0] sample,
  output logic [PERIOD_W-1:0] promedio,
  output logic                valido
);

  localparam int SUMA_W   = PERIOD_W + PROM_LOG2;
  localparam int CUENTA_W = $clog2(PROM_N + 1);
  localparam logic [CUENTA_W-1:0] LLENO = CUENTA_W'(PROM_N);

  logic [PERIOD_W-1:0] muestras [PROM_N];
  logic [SUMA_W-1:0]   suma;
  logic [CUENTA_W-1:0] cuenta;

  // rearm only restarts the sample count: stale entries age out of the window
  // as new samples arrive, so the sum stays exact and the mean can hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PROM_N; i++) muestras[i] <= '0;
      suma     <= '0;
      cuenta   <= '0;
      promedio <= '0;
      valido   <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < PROM_N; i++) muestras[i] <= '0;
      suma     <= '0;
      cuenta   <= '0;
      promedio <= '0;
      valido   <= 1'b0;
    end else begin
      if (push) begin
        muestras[0] <= sample;
        for (int i = 1; i < PROM_N; i++) muestras[i] <= muestras[i-1];
        suma <= suma + SUMA_W'(sample) - SUMA_W'(muestras[PROM_N-1]);
        if (cuenta != LLENO) cuenta <= cuenta + CUENTA_W'(1);
      end
      promedio <= PERIOD_W'(suma >> PROM_LOG2);
      valido   <= (cuenta == LLENO);
      if (rearm) begin
        cuenta <= '0;
        valido <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/medidor_periodo_linea.sv
// rtl/medidor_periodo_linea.sv - line-mark interval, average, odometry total, stall and arrival flags
module medidor_periodo_linea
  import medidor_linea_pkg::*;
#(
  parameter int PERIOD_W     = 24,
  parameter int STALL_CYCLES = 25000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          conteo,
  input  logic [7:0]          objetivo,
  input  logic                limpiar,
  output logic [PERIOD_W-1:0] periodo,
  output logic [PERIOD_W-1:0] periodo_prom,
  output logic                valido,
  output logic                detenido,
  output logic [15:0]         marcas,
  output logic                llegada
);

  localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;
  localparam logic [PERIOD_W-1:0] CNT_UNO   = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] STALL_VAL = PERIOD_W'(STALL_CYCLES);

  estado_t             estado;
  logic [7:0]          prev;
  logic [7:0]          delta;
  logic [PERIOD_W-1:0] cnt;
  logic                evento;
  logic                publicar;
  logic                atasco;

  // Modular difference so a wrap such as 255 -> 1 still counts 2 marks.
  assign evento   = (conteo != prev) && (conteo != 8'd0);
  assign delta    = conteo - prev;
  assign publicar = evento && (estado == MIDIENDO) && !limpiar;
  assign atasco   = !evento && (estado == MIDIENDO) && (cnt == STALL_VAL) && !limpiar;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= INACTIVO;
      prev     <= 8'd0;
      cnt      <= '0;
      periodo  <= '0;
      detenido <= 1'b0;
      marcas   <= 16'd0;
      llegada  <= 1'b0;
    end else if (limpiar) begin
      estado   <= INACTIVO;
      prev     <= conteo;
      cnt      <= '0;
      periodo  <= '0;
      detenido <= 1'b0;
      marcas   <= 16'd0;
      llegada  <= 1'b0;
    end else begin
      cnt     <= (cnt == CNT_MAX) ? cnt : cnt + CNT_UNO;
      llegada <= llegada | ((objetivo != 8'd0) && (marcas >= {8'd0, objetivo}));
      if (evento) begin
        prev     <= conteo;
        marcas   <= suma_sat(marcas, delta);
        cnt      <= CNT_UNO;
        detenido <= 1'b0;
        if (estado == MIDIENDO) periodo <= cnt;
        estado   <= MIDIENDO;
      end else begin
        if (conteo == 8'd0) prev <= 8'd0;
        if (atasco) begin
          estado   <= DETENIDO;
          detenido <= 1'b1;
        end
      end
    end
  end

  promedio_periodo #(
    .PERIOD_W(PERIOD_W)
  ) u_promedio (
    .clock   (clock),
    .reset   (reset),
    .push    (publicar),
    .clear   (limpiar),
    .rearm   (atasco),
    .sample  (cnt),
    .promedio(periodo_prom),
    .valido  (valido)
  );

endmodule

// File: tb/tb_medidor_periodo_linea.sv
// tb/tb_medidor_periodo_linea.sv - scoreboard bench for medidor_periodo_linea
module tb_medidor_periodo_linea;

  localparam int PW    = 24;
  localparam int STALL = 100;
  localparam int F_PER = 0, F_PROM = 1, F_VAL = 2, F_DET = 3, F_MAR = 4, F_LLE = 5;

  logic          clock    = 1'b0;
  logic          reset    = 1'b0;
  logic [7:0]    conteo   = 8'd0;
  logic [7:0]    objetivo = 8'd0;
  logic          limpiar  = 1'b0;
  logic [PW-1:0] periodo, periodo_prom;
  logic          valido, detenido, llegada;
  logic [15:0]   marcas;

  int tests = 0, fails = 0, ciclo = 0, marcas_exp = 0;

  typedef struct {
    string tag;
    int    campo;
    int    valor;
    int    ciclo;
  } esperado_t;

  esperado_t sb[$];
  esperado_t e_mon;

  medidor_periodo_linea #(
    .PERIOD_W    (PW),
    .STALL_CYCLES(STALL)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .conteo      (conteo),
    .objetivo    (objetivo),
    .limpiar     (limpiar),
    .periodo     (periodo),
    .periodo_prom(periodo_prom),
    .valido      (valido),
    .detenido    (detenido),
    .marcas      (marcas),
    .llegada     (llegada)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int leer(input int campo);
    case (campo)
      F_PER:   return int'(periodo);
      F_PROM:  return int'(periodo_prom);
      F_VAL:   return int'(valido);
      F_DET:   return int'(detenido);
      F_MAR:   return int'(marcas);
      default: return int'(llegada);
    endcase
  endfunction

  // Outputs are sampled on the falling edge; entries are queued in cycle order.
  always @(negedge clock) begin
    ciclo++;
    while (sb.size() > 0 && sb[0].ciclo <= ciclo) begin
      e_mon = sb.pop_front();
      check_eq(e_mon.tag, leer(e_mon.campo), e_mon.valor);
    end
  end

  task automatic espera(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic esperar(input string tag, input int campo, input int valor, input int off);
    esperado_t e;
    e.tag   = tag;
    e.campo = campo;
    e.valor = valor;
    e.ciclo = ciclo + off;
    sb.push_back(e);
  endtask

  task automatic marca(input logic [7:0] v, input int delta);
    conteo     = v;
    marcas_exp = marcas_exp + delta;
    esperar("marcas", F_MAR, marcas_exp, 1);
  endtask

  task automatic todo_cero(input string tag);
    esperar({tag, "_per"},  F_PER,  0, 1);
    esperar({tag, "_prom"}, F_PROM, 0, 1);
    esperar({tag, "_val"},  F_VAL,  0, 1);
    esperar({tag, "_det"},  F_DET,  0, 1);
    esperar({tag, "_mar"},  F_MAR,  0, 1);
    esperar({tag, "_lle"},  F_LLE,  0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    espera(2);
    todo_cero("rst");
    espera(1);
    reset = 1'b1;
    espera(2);

    marca(1, 1); esperar("arma_per", F_PER, 0, 1); espera(40);
    marca(2, 1); esperar("per_1", F_PER, 40, 1); espera(40);
    marca(3, 1); esperar("per_2", F_PER, 40, 1); espera(40);
    marca(4, 1); esperar("val_3", F_VAL, 0, 2); espera(40);
    marca(5, 1); esperar("per_4", F_PER, 40, 1);
    esperar("prom_4", F_PROM, 40, 2); esperar("val_4", F_VAL, 1, 2); espera(20);

    marca(6, 1); esperar("per_20", F_PER, 20, 1); esperar("prom_35", F_PROM, 35, 2); espera(40);
    marca(7, 1); esperar("per_40", F_PER, 40, 1); espera(60);
    marca(8, 1); esperar("per_60", F_PER, 60, 1); esperar("prom_40", F_PROM, 40, 2); espera(80);
    marca(9, 1); esperar("per_80", F_PER, 80, 1);
    esperar("prom_lag", F_PROM, 40, 1); esperar("prom_50", F_PROM, 50, 2);

    esperar("det_antes", F_DET, 0, STALL);
    esperar("det", F_DET, 1, STALL + 1);
    esperar("det_val", F_VAL, 0, STALL + 1);
    esperar("det_per", F_PER, 80, STALL + 1);
    esperar("det_prom", F_PROM, 50, STALL + 1);
    espera(110);
    marca(10, 1); esperar("rearme_det", F_DET, 0, 1); esperar("rearme_per", F_PER, 80, 1); espera(30);
    marca(11, 1); esperar("per_30", F_PER, 30, 1); esperar("val_rearme", F_VAL, 0, 2); espera(30);

    marca(254, 243); esperar("per_254", F_PER, 30, 1); espera(25);
    marca(1, 3); esperar("wrap_per", F_PER, 25, 1); espera(10);
    marca(0, 0); esperar("cero_per", F_PER, 25, 1); espera(10);
    marca(1, 1); esperar("tras_cero_per", F_PER, 20, 1); espera(10);

    limpiar = 1'b1; marcas_exp = 0; todo_cero("lim1"); espera(1); limpiar = 1'b0;
    objetivo = 8'd3;
    marca(0, 0); espera(5);
    marca(1, 1); esperar("lle_1", F_LLE, 0, 1); espera(5);
    marca(2, 1); espera(5);
    marca(3, 1); esperar("lle_pre", F_LLE, 0, 1); esperar("lle", F_LLE, 1, 2); espera(5);
    objetivo = 8'd10; esperar("lle_sticky", F_LLE, 1, 3); espera(5);
    limpiar = 1'b1; marcas_exp = 0; todo_cero("lim2"); espera(1); limpiar = 1'b0;

    marca(5, 2); espera(10);
    limpiar = 1'b1; conteo = 8'd6; marcas_exp = 0;
    esperar("coinc_mar", F_MAR, 0, 1); esperar("coinc_prev6", F_MAR, 0, 10);
    espera(1); limpiar = 1'b0; espera(11);
    marca(7, 1); esperar("inact_per", F_PER, 0, 1); espera(15);
    marca(8, 1); esperar("per_15", F_PER, 15, 1); espera(5);

    reset = 1'b0; #2;
    check_eq("areset_per", int'(periodo), 0);
    check_eq("areset_prom", int'(periodo_prom), 0);
    check_eq("areset_mar", int'(marcas), 0);
    check_eq("areset_det", int'(detenido), 0);
    espera(3);
    reset = 1'b1; marcas_exp = 8;
    esperar("post_rst_mar", F_MAR, 8, 1); esperar("post_rst_per", F_PER, 0, 1); espera(12);
    marca(9, 1); esperar("post_rst_per12", F_PER, 12, 1); espera(3);

    check_eq("sb_vacio", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
